// File: rtl/burst_mode_ctrl_pkg.sv
// Shared definitions for the CellularRAM burst control path: datapath Mode
// codes, controller state encoding and BCR field constants. LAT_COUNT and the
// BCR latency code both derive from BCR_LAT_CODE so they cannot drift apart.
package burst_mode_ctrl_pkg;

  // Datapath mode select driven to the burst-mode datapath
  typedef enum logic [2:0] {
    MODE_IDLE  = 3'b000,
    MODE_READ  = 3'b001,
    MODE_CON   = 3'b010,
    MODE_WRITE = 3'b011,
    MODE_ADDR  = 3'b100
  } mode_e;

  // Controller states
  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_CFG_WR,
    ST_CFG_REC,
    ST_IDLE,
    ST_ADDR,
    ST_LAT,
    ST_DATA,
    ST_FINISH
  } state_e;

  // BCR fields (address-bus encoded configuration word)
  localparam logic [1:0]  BCR_REG_SEL     = 2'b10;  // A[19:18]: select BCR
  localparam logic        BCR_OP_SYNC     = 1'b0;   // A[15]: synchronous burst
  localparam logic        BCR_INIT_VAR    = 1'b0;   // A[14]: variable latency
  localparam int unsigned BCR_LAT_CODE    = 3;      // A[13:11]: latency code
  localparam logic        BCR_WAIT_POL_HI = 1'b1;   // A[10]: WAIT active high
  localparam logic        BCR_WAIT_EARLY  = 1'b1;   // A[8]: WAIT one clock early
  localparam logic [1:0]  BCR_DRIVE       = 2'b01;  // A[5:4]: half drive
  localparam logic        BCR_NO_WRAP     = 1'b1;   // A[3]: no burst wrap
  localparam logic [2:0]  BCR_BLEN_16     = 3'b011; // A[2:0]: 16-word burst

  // Cycles from the address cycle to first data, taken from the BCR code
  localparam int unsigned DEF_LAT_COUNT = BCR_LAT_CODE;

  // Full BCR word presented on the address bus during the config write
  localparam logic [22:0] BCR_WORD = {3'b000, BCR_REG_SEL, 2'b00, BCR_OP_SYNC,
                                      BCR_INIT_VAR, BCR_LAT_CODE[2:0],
                                      BCR_WAIT_POL_HI, 1'b0, BCR_WAIT_EARLY,
                                      2'b00, BCR_DRIVE, BCR_NO_WRAP, BCR_BLEN_16};

  // RCR default: no deep power-down, full array refresh
  localparam logic [1:0]  RCR_REG_SEL = 2'b00;

  // Largest of three cycle counts, used to size the shared delay counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_delay_counter.sv
// Loadable down-counter with zero flag, shared by power-up, config and latency timing.
// Latency: zero_o is registered-state decode; a load is visible the next cycle.
// Backpressure: none; saturates at zero until reloaded.
module mem_delay_counter #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over counting; count stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Counter register; reset preloads the power-up interval
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/burst_mode_ctrl.sv
// Control FSM for the CellularRAM sync burst path: power-up, BCR write, fixed bursts.
// Latency: Start at edge k -> ADDR at k+1, LAT for LAT_COUNT cycles, then DATA.
// Backpressure: MemWait (registered) stalls beats; WAIT_TIMEOUT stalls abort the burst.
module burst_mode_ctrl
  import burst_mode_ctrl_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES = 7500,
  parameter int unsigned CFG_HOLD     = 4,
  parameter int unsigned LAT_COUNT    = DEF_LAT_COUNT,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned WAIT_TIMEOUT = 15
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       RW,
  input  logic       MemWait,
  output logic [2:0] Mode,
  output logic       MemCe_n,
  output logic       MemOe_n,
  output logic       MemWe_n,
  output logic       MemAdv_n,
  output logic       MemCre,
  output logic       MemClkEn,
  output logic       Busy,
  output logic       WordValid,
  output logic       WordReq,
  output logic       Done,
  output logic       Error
);

  localparam int unsigned DLY_MAX = max3(PWRUP_CYCLES, CFG_HOLD, LAT_COUNT);
  localparam int unsigned DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN + 1);
  localparam int unsigned WAIT_W  = $clog2(WAIT_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              rw_q, rw_d;
  logic              abort_q, abort_d;
  logic              mem_wait_q;
  logic              dly_load;
  logic [DLY_W-1:0]  dly_val;
  logic              dly_zero;

  // One counter times PWRUP, CFG_WR and LAT; reset preloads the power-up wait
  mem_delay_counter #(
    .W       (DLY_W),
    .RST_VAL (DLY_W'(PWRUP_CYCLES - 1))
  ) u_dly (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (dly_load),
    .load_val_i (dly_val),
    .zero_o     (dly_zero)
  );

  // Next-state logic: sequencing, beat/wait counting and abort detection
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    rw_d     = rw_q;
    abort_d  = abort_q;
    dly_load = 1'b0;
    dly_val  = '0;
    unique case (state_q)
      ST_PWRUP: begin
        if (dly_zero) begin
          state_d  = ST_CFG_WR;
          dly_load = 1'b1;
          dly_val  = DLY_W'(CFG_HOLD - 1);
        end
      end
      ST_CFG_WR: begin
        if (dly_zero) state_d = ST_CFG_REC;
      end
      ST_CFG_REC: state_d = ST_IDLE;
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_ADDR;
          rw_d    = RW;
          beat_d  = '0;
          wait_d  = '0;
          abort_d = 1'b0;
        end
      end
      ST_ADDR: begin
        state_d  = ST_LAT;
        dly_load = 1'b1;
        dly_val  = DLY_W'(LAT_COUNT - 1);
      end
      ST_LAT: begin
        if (dly_zero) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!mem_wait_q) begin
          beat_d = beat_q + BEAT_W'(1);
          wait_d = '0;
          if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = ST_FINISH;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(WAIT_TIMEOUT - 1)) begin
            state_d = ST_FINISH;
            abort_d = 1'b1;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_PWRUP;
    endcase
  end

  // State and counter registers; reset restarts the power-up sequence
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_PWRUP;
      beat_q     <= '0;
      wait_q     <= '0;
      rw_q       <= 1'b0;
      abort_q    <= 1'b0;
      mem_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      wait_q     <= wait_d;
      rw_q       <= rw_d;
      abort_q    <= abort_d;
      mem_wait_q <= MemWait;
    end
  end

  // Moore output decode from registered state, direction and WAIT
  always_comb begin
    Mode      = MODE_IDLE;
    MemCe_n   = 1'b1;
    MemOe_n   = 1'b1;
    MemWe_n   = 1'b1;
    MemAdv_n  = 1'b1;
    MemCre    = 1'b0;
    MemClkEn  = 1'b0;
    Busy      = 1'b1;
    WordValid = 1'b0;
    WordReq   = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    unique case (state_q)
      ST_CFG_WR: begin
        Mode     = MODE_CON;
        MemCre   = 1'b1;
        MemCe_n  = 1'b0;
        MemWe_n  = 1'b0;
        MemAdv_n = 1'b0;
      end
      ST_IDLE: Busy = 1'b0;
      ST_ADDR: begin
        Mode     = MODE_ADDR;
        MemCe_n  = 1'b0;
        MemAdv_n = 1'b0;
        MemWe_n  = ~rw_q;
        MemClkEn = 1'b1;
      end
      ST_LAT, ST_DATA: begin
        Mode     = rw_q ? MODE_READ : MODE_WRITE;
        MemCe_n  = 1'b0;
        MemClkEn = 1'b1;
        MemOe_n  = ~rw_q;
        if (state_q == ST_DATA) begin
          WordValid = rw_q & ~mem_wait_q;
          WordReq   = ~rw_q & ~mem_wait_q;
        end
      end
      ST_FINISH: begin
        Done  = ~abort_q;
        Error = abort_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_burst_mode_ctrl.sv
// Self-checking bench for burst_mode_ctrl: directed sequence of bursts with a
// behavioural expectation built from the protocol phases and the WAIT rules.
module tb_burst_mode_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       RW = 1'b0;
  logic       MemWait = 1'b0;
  logic [2:0] Mode;
  logic       MemCe_n, MemOe_n, MemWe_n, MemAdv_n, MemCre, MemClkEn;
  logic       Busy, WordValid, WordReq, Done, Error;

  int tests = 0;
  int fails = 0;
  logic mw_prev = 1'b0;

  burst_mode_ctrl #(
    .PWRUP_CYCLES (8),
    .CFG_HOLD     (4),
    .LAT_COUNT    (3),
    .BURST_LEN    (16),
    .WAIT_TIMEOUT (15)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .RW        (RW),
    .MemWait   (MemWait),
    .Mode      (Mode),
    .MemCe_n   (MemCe_n),
    .MemOe_n   (MemOe_n),
    .MemWe_n   (MemWe_n),
    .MemAdv_n  (MemAdv_n),
    .MemCre    (MemCre),
    .MemClkEn  (MemClkEn),
    .Busy      (Busy),
    .WordValid (WordValid),
    .WordReq   (WordReq),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clock = ~Clock;

  logic [13:0] obs;
  assign obs = {Mode, MemCe_n, MemOe_n, MemWe_n, MemAdv_n, MemCre, MemClkEn,
                Busy, WordValid, WordReq, Done, Error};

  typedef enum {P_PWRUP, P_CFG_WR, P_CFG_REC, P_IDLE, P_ADDR, P_LAT, P_DATA, P_FINISH} phase_t;

  // Expected output vector for a protocol phase
  function automatic logic [13:0] expv(input phase_t p, input bit rw, input bit beat,
                                       input bit ok);
    logic [2:0] m;
    logic ce, oe, we, adv, cre, clk, busy, wv, wr, dn, er;
    m = 3'b000; ce = 1; oe = 1; we = 1; adv = 1; cre = 0; clk = 0; busy = 1;
    wv = 0; wr = 0; dn = 0; er = 0;
    case (p)
      P_CFG_WR: begin m = 3'b010; cre = 1; ce = 0; we = 0; adv = 0; end
      P_IDLE:   busy = 0;
      P_ADDR:   begin m = 3'b100; ce = 0; adv = 0; we = !rw; clk = 1; end
      P_LAT, P_DATA: begin
        m = rw ? 3'b001 : 3'b011; ce = 0; clk = 1; oe = !rw;
        if (p == P_DATA) begin wv = rw & beat; wr = !rw & beat; end
      end
      P_FINISH: begin dn = ok; er = !ok; end
      default: ;
    endcase
    return {m, ce, oe, we, adv, cre, clk, busy, wv, wr, dn, er};
  endfunction

  task automatic tick;
    mw_prev = MemWait;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Power-up / config sequence starting in the first cycle after reset
  task automatic powerup;
    phase_t p;
    for (int i = 0; i < 14; i++) begin
      p = (i < 8) ? P_PWRUP : (i < 12) ? P_CFG_WR : (i == 12) ? P_CFG_REC : P_IDLE;
      chk($sformatf("pwrup_c%0d", i), obs, expv(p, 0, 0, 0));
      if (i < 13) tick();
    end
  endtask

  // WAIT drive policy: 0 none, 1 random, 2 stuck high, 3 two-cycle stall after beat 5
  function automatic logic next_mw(input int pol, input int pulse);
    if (pol == 2) return 1'b1;
    if (pol == 1) return ($urandom_range(0, 3) == 0);
    if (pol == 3) return (pulse > 0);
    return 1'b0;
  endfunction

  // One burst from an IDLE cycle through the IDLE cycle after FINISH
  task automatic burst(input bit rw, input int pol, input bit hold, input int rst_beat);
    int beats, run, dcyc, seen, pulse;
    bit wq, ok, fin;
    Start = 1'b1; RW = rw; MemWait = 1'b0;
    tick();
    Start = hold;
    chk("addr", obs, expv(P_ADDR, rw, 0, 0));
    MemWait = next_mw(pol, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat%0d", i), obs, expv(P_LAT, rw, 0, 0));
      MemWait = next_mw(pol, 0);
    end
    beats = 0; run = 0; dcyc = 0; seen = 0; pulse = 0; ok = 0; fin = 0;
    while (!fin) begin
      tick();
      wq = mw_prev;
      dcyc++;
      chk($sformatf("data_d%0d", dcyc), obs, expv(P_DATA, rw, !wq, 0));
      seen += int'(WordValid | WordReq);
      if (!wq) begin
        beats++;
        run = 0;
        if (beats == 16) begin fin = 1; ok = 1; end
      end else begin
        run++;
        if (run == 15) fin = 1;
      end
      if (rst_beat >= 0 && !wq && beats == rst_beat) begin
        Reset = 1'b1; MemWait = 1'b0;
        tick();
        chk("rst_mid", obs, expv(P_PWRUP, 0, 0, 0));
        Reset = 1'b0;
        powerup();
        return;
      end
      if (pol == 3 && !wq && beats == 5) pulse = 2;
      MemWait = next_mw(pol, pulse);
      if (pulse > 0) pulse--;
    end
    tick();
    chk("finish", obs, expv(P_FINISH, rw, 0, ok));
    MemWait = 1'b0;
    chk("beat_total", seen, beats);
    tick();
    chk("idle_after", obs, expv(P_IDLE, 0, 0, 0));
  endtask

  initial begin
    Reset = 1'b1;
    tick();
    chk("reset", obs, expv(P_PWRUP, 0, 0, 0));
    tick();
    Reset = 1'b0;
    powerup();

    burst(1'b1, 0, 1'b0, -1);   // plain read
    burst(1'b0, 3, 1'b0, -1);   // write with two-cycle stall
    burst(1'b1, 2, 1'b0, -1);   // wait timeout abort
    burst(1'b0, 0, 1'b0, -1);   // recovery after abort
    burst(1'b1, 0, 1'b1, -1);   // Start held across passes
    burst(1'b1, 0, 1'b1, -1);
    burst(1'b1, 0, 1'b0, -1);
    for (int n = 0; n < 6; n++) begin
      burst(1'($urandom_range(0, 1)), 1, 1'b0, -1);
    end
    burst(1'b1, 0, 1'b0, 7);    // reset mid-burst replays power-up
    burst(1'b0, 1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
